huffman_symbol_decoder: RTL and testbench
=========================================

// Module: huffman_symbol_decoder
// PURPOSE
//  Bit-serial Huffman symbol decoder. Sits directly downstream of huffman_builder and walks its finished
//  2-D tree one code bit at a time. Each bit is consumed from the inflate bit-reader via a valid/ready
//  handshake. When a leaf is reached, the block emits the decoded literal/length or distance symbol.
//  One instance is used per tree: the literal/length tree (NUMCODES=288) and the distance tree (NUMCODES=32).
// PARAMETERS
//  NUMCODES   288  symbol alphabet size; must match the paired builder
//  BITLENGTH  15   maximum legal code length; a longer path is an error
//  OUTWIDTH   10   tree entry width; must match the paired builder; must be >= clogb2(2*NUMCODES-1)
//  AW = clogb2(2*NUMCODES-1)  tree address width (localparam); SW = clogb2(NUMCODES-1) symbol width (localparam)
// PORTS
//  clk          in   1         clock
//  rstn         in   1         asynchronous active-low reset
//  istart       in   1         synchronous restart: return to IDLE, clear the error flag and path state
//  tree_done    in   1         builder done (level); the tree may be read only while this is high
//  tree_rdaddr  out  AW        tree read address to builder rdaddr (registered)
//  tree_rddata  in   OUTWIDTH  builder rddata; valid 1 cycle after the builder samples tree_rdaddr
//  ibit_en      in   1         code bit valid
//  ibit         in   1         code bit, in order from MSB of the Huffman code
//  ibit_rdy     out  1         decoder accepts a bit this cycle (registered)
//  osym_en      out  1         one-cycle pulse: a symbol is decoded
//  osym         out  SW        decoded symbol; held until the next osym_en
//  oerr         out  1         sticky error: invalid node or code longer than BITLENGTH
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, treepos=0, depth=0.
//  FSM: IDLE -> BIT when tree_done=1 and oerr=0.
//  BIT: ibit_rdy=1. When ibit_en=1:
//    - tree_rdaddr <= {treepos, ibit}, i.e. 2*treepos+ibit, truncated to AW bits
//    - depth <= depth+1
//    - go to WAIT
//  WAIT: the builder latches its read. Go to EVAL.
//  EVAL: let v = tree_rddata.
//    - v < NUMCODES: leaf. osym <= v; osym_en pulses next cycle; treepos <= 0; depth <= 0; go to BIT.
//    - else if (v-NUMCODES) >= NUMCODES-1, or depth == BITLENGTH: oerr <= 1; go to ERR.
//    - else: treepos <= v-NUMCODES; go to BIT.
//  ERR: ibit_rdy=0; the block stays here until istart. oerr stays high.
//  Throughput: 3 cycles per bit. For the final bit accepted at edge E0, osym_en is high in the cycle after
//   E2, and ibit_rdy returns high in that same cycle.
//  ibit_rdy is deasserted outside BIT and in the cycle a bit is accepted. A bit with ibit_en=1 while
//   ibit_rdy=0 is ignored and is not consumed.
//  tree_done drops in any non-IDLE state (builder re-running): abort to IDLE with treepos=0 and depth=0.
//   No osym_en is produced and oerr is unchanged.
//  istart has priority over all other events, including simultaneous ibit_en and a leaf found in EVAL.
//   In that case the leaf is not emitted.
//  Reset mid-walk: asynchronous return to the reset state. A partial code is discarded.
//  Arithmetic: v-NUMCODES is computed at OUTWIDTH+1 bits, so no wrap can fake a valid node.
//  An unfilled tree entry reads as 0 and decodes as symbol 0. Builder tree completeness is an upstream
//   guarantee and is not checked here.
// TESTING  (small config NUMCODES=4, BITLENGTH=3, OUTWIDTH=4, builder model loaded with bitlens {2,1,3,3}:
//           codes sym1=0, sym0=10, sym2=110, sym3=111)
//  1. Bits 0 | 1,0 | 1,1,0 | 1,1,1 back-to-back -> osym 1,0,2,3. Each osym_en is exactly 1 cycle.
//     Total 27 cycles of bit traffic, checked against the 3-cycle/bit throughput.
//  2. Reset values: after rstn release with tree_done=0 -> ibit_rdy=0, osym_en=0, oerr=0.
//     Raise tree_done -> ibit_rdy=1 on the next cycle.
//  3. Corrupt the model so node 1 child reads 7 (7-4=3 >= 3) -> after bits 1,1: oerr=1, ibit_rdy=0 persists.
//     Then istart -> oerr=0 and decoding resumes.
//  4. Depth: model returns internal node 4 for every read; feed 3 bits -> oerr set at the 3rd EVAL, no osym_en.
//  5. Drop tree_done after bit "1" (mid-code). Re-raise it and send 0 -> osym=1, with the partial code
//     discarded.
//  6. Hold ibit_en=1 with random gaps plus istart asserted in EVAL of a leaf -> no osym_en;
//     no bit consumed while ibit_rdy=0.

Source files
------------

// File: rtl/huffman_symbol_decoder.sv
// huffman_symbol_decoder
// Bit-serial Huffman symbol decoder. Walks the 2-D tree produced by the
// paired huffman_builder one code bit at a time. Every tree row holds two
// entries (bit 0 / bit 1). An entry below NUMCODES is a leaf carrying the
// symbol. Any other entry points at the next row, stored as NUMCODES+row.
// Each code bit costs three cycles:
//   accept the bit and present the address,
//   let the builder register its read,
//   evaluate the returned entry.
// Any illegal entry, or a path longer than BITLENGTH, parks the block in a
// sticky error state that only istart (or reset) clears.

module huffman_symbol_decoder #(
    parameter int NUMCODES  = 288,
    parameter int BITLENGTH = 15,
    parameter int OUTWIDTH  = 10,
    // Tree address width: bits needed to index 2*NUMCODES-1 entries
    localparam int AW = $clog2(2 * NUMCODES),
    // Symbol width: bits needed to hold NUMCODES-1
    localparam int SW = $clog2(NUMCODES)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                istart,
    input  logic                tree_done,
    output logic [AW-1:0]       tree_rdaddr,
    input  logic [OUTWIDTH-1:0] tree_rddata,
    input  logic                ibit_en,
    input  logic                ibit,
    output logic                ibit_rdy,
    output logic                osym_en,
    output logic [SW-1:0]       osym,
    output logic                oerr
);

    // Depth counter width: enough to count up to BITLENGTH
    localparam int DW = $clog2(BITLENGTH + 1);

    // The entry compares use one extra bit, so that v-NUMCODES can never
    // wrap around into a small, valid-looking row index.
    localparam logic [OUTWIDTH:0] NUM_EXT    = (OUTWIDTH + 1)'(NUMCODES);
    localparam logic [OUTWIDTH:0] NODE_LIMIT = (OUTWIDTH + 1)'(NUMCODES - 1);
    localparam logic [DW-1:0]     DEPTH_MAX  = DW'(BITLENGTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT,
        ST_WAIT,
        ST_EVAL,
        ST_ERR
    } state_t;

    state_t            state;

    // Row index of the current tree node.
    // The largest legal row is NUMCODES-2, so it fits in AW-1 bits.
    // {treepos, ibit} is then exactly AW bits wide.
    logic [AW-2:0]     treepos;

    logic [DW-1:0]     depth;

    logic [OUTWIDTH:0] rd_ext;
    logic [OUTWIDTH:0] node_idx;
    logic              is_leaf;
    logic              bad_node;
    logic              at_max_depth;

    // Classify the entry returned by the builder: leaf, legal internal row, or illegal
    always_comb begin
        rd_ext       = {1'b0, tree_rddata};
        node_idx     = rd_ext - NUM_EXT;
        is_leaf      = (rd_ext < NUM_EXT);
        bad_node     = (node_idx >= NODE_LIMIT);
        at_max_depth = (depth == DEPTH_MAX);
    end

    // Walk FSM: restart and tree loss take priority, then one step of the tree walk per state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            treepos     <= '0;
            depth       <= '0;
            tree_rdaddr <= '0;
            ibit_rdy    <= 1'b0;
            osym_en     <= 1'b0;
            osym        <= '0;
            oerr        <= 1'b0;
        end else begin
            osym_en <= 1'b0;

            if (istart) begin
                // Restart wins over everything, even a leaf found this cycle.
                state    <= ST_IDLE;
                treepos  <= '0;
                depth    <= '0;
                ibit_rdy <= 1'b0;
                oerr     <= 1'b0;
            end else if ((state != ST_IDLE) && !tree_done) begin
                // The builder is rebuilding the tree, so the partial code is meaningless.
                state    <= ST_IDLE;
                treepos  <= '0;
                depth    <= '0;
                ibit_rdy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tree_done && !oerr) begin
                            state    <= ST_BIT;
                            ibit_rdy <= 1'b1;
                        end
                    end

                    ST_BIT: begin
                        if (ibit_en) begin
                            tree_rdaddr <= {treepos, ibit};
                            depth       <= depth + DW'(1);
                            ibit_rdy    <= 1'b0;
                            state       <= ST_WAIT;
                        end
                    end

                    ST_WAIT: begin
                        state <= ST_EVAL;
                    end

                    ST_EVAL: begin
                        if (is_leaf) begin
                            osym     <= tree_rddata[SW-1:0];
                            osym_en  <= 1'b1;
                            treepos  <= '0;
                            depth    <= '0;
                            ibit_rdy <= 1'b1;
                            state    <= ST_BIT;
                        end else if (bad_node || at_max_depth) begin
                            oerr  <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            treepos  <= node_idx[AW-2:0];
                            ibit_rdy <= 1'b1;
                            state    <= ST_BIT;
                        end
                    end

                    ST_ERR: begin
                        ibit_rdy <= 1'b0;
                    end

                    default: begin
                        state    <= ST_IDLE;
                        ibit_rdy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_huffman_symbol_decoder.sv
// tb_huffman_symbol_decoder
// Directed bench for huffman_symbol_decoder in the small configuration
// (NUMCODES=4, BITLENGTH=3, OUTWIDTH=4).
// A behavioural builder supplies the tree for bit lengths {2,1,3,3}:
//   sym1 = 0, sym0 = 10, sym2 = 110, sym3 = 111
// Tree rows (entry 4+n points at row n):
//   row0: {1, 5}
//   row1: {0, 6}
//   row2: {2, 3}

module tb_huffman_symbol_decoder;

    localparam int NUMCODES  = 4;
    localparam int BITLENGTH = 3;
    localparam int OUTWIDTH  = 4;

    typedef struct {
        logic       bitv;
        logic       expEn;
        logic [1:0] expSym;
    } vec_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic                istart;
    logic                tree_done;
    logic [2:0]          tree_rdaddr;
    logic [OUTWIDTH-1:0] tree_rddata = '0;
    logic                ibit_en;
    logic                ibit;
    logic                ibit_rdy;
    logic                osym_en;
    logic [1:0]          osym;
    logic                oerr;

    logic [3:0] mem [0:7];
    logic [1:0] symQ [$];
    int         vecCount     = 0;
    int         missCount    = 0;
    int         cycleCnt     = 0;
    int         lastAccept   = 0;
    int         firstAccept  = 0;
    int         lastSymCycle = 0;
    int         widthErr     = 0;
    bit         prevEn       = 1'b0;
    vec_t       vecs [9];

    huffman_symbol_decoder #(
        .NUMCODES (NUMCODES),
        .BITLENGTH(BITLENGTH),
        .OUTWIDTH (OUTWIDTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .istart     (istart),
        .tree_done  (tree_done),
        .tree_rdaddr(tree_rdaddr),
        .tree_rddata(tree_rddata),
        .ibit_en    (ibit_en),
        .ibit       (ibit),
        .ibit_rdy   (ibit_rdy),
        .osym_en    (osym_en),
        .osym       (osym),
        .oerr       (oerr)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Edge counter used to measure decode latency
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Builder model: registered read, data valid one cycle after the address is sampled
    always @(posedge clk) tree_rddata <= mem[tree_rdaddr];

    // Symbol monitor: samples just after each edge, queues symbols and flags over-long pulses
    always @(posedge clk) begin
        #1;
        if (osym_en === 1'b1) begin
            symQ.push_back(osym);
            lastSymCycle = cycleCnt;
            if (prevEn) widthErr++;
        end
        prevEn = (osym_en === 1'b1);
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        vecCount++;
        missCount++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    task automatic loadTree();
        mem[0] = 4'd1; mem[1] = 4'd5;
        mem[2] = 4'd0; mem[3] = 4'd6;
        mem[4] = 4'd2; mem[5] = 4'd3;
        mem[6] = 4'd0; mem[7] = 4'd0;
    endtask

    // Wait (at negedges) for ibit_rdy, offer one bit, return at the negedge after acceptance
    task automatic applyStimulus(input logic b);
        int n;
        n = 0;
        while (ibit_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ibit_rdy !== 1'b1) begin
            reportTimeout("bit_rdy_wait");
        end else begin
            ibit_en = 1'b1;
            ibit    = b;
            @(posedge clk);
            #1;
            lastAccept = cycleCnt;
            @(negedge clk);
            ibit_en = 1'b0;
        end
    endtask

    // Wait (at negedges) for the monitor to queue a symbol
    task automatic waitSym(output logic [1:0] s, output bit got);
        int n;
        n = 0;
        s = 2'bxx;
        while (symQ.size() == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        got = (symQ.size() > 0);
        if (got) s = symQ.pop_front();
        else     reportTimeout("sym_wait");
    endtask

    task automatic pulseIstart();
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
    endtask

    initial begin
        logic [1:0] s;
        bit         got;
        logic       stream [9];
        logic [1:0] expStream [4];
        int         idx;
        int         n;
        logic       rdyNow;

        rstn      = 1'b0;
        istart    = 1'b0;
        tree_done = 1'b0;
        ibit_en   = 1'b0;
        ibit      = 1'b0;
        loadTree();

        vecs[0] = '{1'b0, 1'b1, 2'd1};
        vecs[1] = '{1'b1, 1'b0, 2'd0};
        vecs[2] = '{1'b0, 1'b1, 2'd0};
        vecs[3] = '{1'b1, 1'b0, 2'd0};
        vecs[4] = '{1'b1, 1'b0, 2'd0};
        vecs[5] = '{1'b0, 1'b1, 2'd2};
        vecs[6] = '{1'b1, 1'b0, 2'd0};
        vecs[7] = '{1'b1, 1'b0, 2'd0};
        vecs[8] = '{1'b1, 1'b1, 2'd3};

        stream       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        expStream    = '{2'd3, 2'd0, 2'd1, 2'd2};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset_rdy",    32'(ibit_rdy),    0);
        checkOutput("reset_sym_en", 32'(osym_en),     0);
        checkOutput("reset_err",    32'(oerr),        0);
        checkOutput("reset_osym",   32'(osym),        0);
        checkOutput("reset_addr",   32'(tree_rdaddr), 0);
        tree_done = 1'b1;
        @(negedge clk);
        checkOutput("rdy_after_done", 32'(ibit_rdy), 1);

        $display("[TB] back-to-back codes");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].bitv);
            if (i == 0) firstAccept = lastAccept;
            if (vecs[i].expEn) begin
                waitSym(s, got);
                if (got) begin
                    checkOutput($sformatf("t1_sym%0d", i), 32'(s),        32'(vecs[i].expSym));
                    checkOutput($sformatf("t1_rdy%0d", i), 32'(ibit_rdy), 1);
                end
            end
        end
        checkOutput("t1_span",  lastSymCycle - firstAccept + 1, 27);
        checkOutput("t1_width", widthErr,                       0);
        checkOutput("t1_extra", symQ.size(),                    0);

        $display("[TB] invalid node");
        mem[3] = 4'd7;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        ibit_en = 1'b1;
        ibit    = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t3_err",   32'(oerr),        1);
        checkOutput("t3_rdy",   32'(ibit_rdy),    0);
        checkOutput("t3_addr",  32'(tree_rdaddr), 3);
        checkOutput("t3_nosym", symQ.size(),      0);
        ibit_en = 1'b0;
        mem[3] = 4'd6;
        pulseIstart();
        checkOutput("t3_err_clr", 32'(oerr), 0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        waitSym(s, got);
        if (got) checkOutput("t3_resume_sym", 32'(s), 2);

        $display("[TB] depth limit");
        for (int i = 0; i < 8; i++) mem[i] = 4'd4;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        repeat (2) @(negedge clk);
        checkOutput("t4_err_d2", 32'(oerr),     0);
        checkOutput("t4_rdy_d2", 32'(ibit_rdy), 1);
        applyStimulus(1'b0);
        repeat (2) @(negedge clk);
        checkOutput("t4_err_d3", 32'(oerr),     1);
        checkOutput("t4_rdy_d3", 32'(ibit_rdy), 0);
        checkOutput("t4_nosym",  symQ.size(),   0);
        loadTree();
        pulseIstart();

        $display("[TB] tree_done drop mid-code");
        applyStimulus(1'b1);
        tree_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_rdy",   32'(ibit_rdy), 0);
        checkOutput("t5_nosym", symQ.size(),   0);
        checkOutput("t5_err",   32'(oerr),     0);
        tree_done = 1'b1;
        applyStimulus(1'b0);
        waitSym(s, got);
        if (got) checkOutput("t5_sym", 32'(s), 1);

        $display("[TB] reset mid-walk");
        applyStimulus(1'b1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_rdy",  32'(ibit_rdy),    0);
        checkOutput("rst_addr", 32'(tree_rdaddr), 0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1'b0);
        waitSym(s, got);
        if (got) checkOutput("rst_sym", 32'(s), 1);

        $display("[TB] gapped ibit_en stream");
        idx = 0;
        n   = 0;
        while (idx < 9 && n < 300) begin
            rdyNow  = ibit_rdy;
            ibit_en = ($urandom_range(0, 3) != 0);
            ibit    = stream[idx];
            @(posedge clk);
            if (ibit_en && rdyNow) idx++;
            @(negedge clk);
            n++;
        end
        ibit_en = 1'b0;
        if (idx < 9) reportTimeout("t6_stream");
        for (int i = 0; i < 4; i++) begin
            waitSym(s, got);
            if (got) checkOutput($sformatf("t6_sym%0d", i), 32'(s), 32'(expStream[i]));
        end

        $display("[TB] istart during leaf EVAL");
        applyStimulus(1'b0);
        ibit_en = 1'b1;
        ibit    = 1'b0;
        @(negedge clk);
        istart = 1'b1;
        @(negedge clk);
        istart  = 1'b0;
        ibit_en = 1'b0;
        checkOutput("t6_istart_en",  32'(osym_en),  0);
        checkOutput("t6_istart_rdy", 32'(ibit_rdy), 0);
        @(negedge clk);
        checkOutput("t6_istart_nosym", symQ.size(),   0);
        checkOutput("t6_istart_rdy2",  32'(ibit_rdy), 1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        waitSym(s, got);
        if (got) checkOutput("t6_after_sym", 32'(s), 0);
        repeat (3) @(negedge clk);
        checkOutput("final_extra", symQ.size(), 0);
        checkOutput("final_width", widthErr,    0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
